// File: rtl/fwd_data_pipe.sv
// Operand-forwarding data pipeline: carries EX2 results through MEM1..WRITTEN slots,
// merges load data on the MEM3->WB step and serves forwarded operands by select.
module fwd_data_pipe #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  EX2_VALID,
  input  logic [1:0]            EX2_TYPE,
  input  logic [4:0]            EX2_RD,
  input  logic [DATA_WIDTH-1:0] EX2_DATA,
  input  logic [DATA_WIDTH-1:0] LOAD_DATA,
  input  logic                  DATA_CACHE_READY,
  input  logic                  INS_CACHE_READY,
  input  logic                  STALL_ENABLE_FB,
  input  logic                  FLUSH,
  input  logic [2:0]            MUX1_SELECT,
  input  logic [2:0]            MUX2_SELECT,
  input  logic [DATA_WIDTH-1:0] RF1_DATA,
  input  logic [DATA_WIDTH-1:0] RF2_DATA,
  output logic [DATA_WIDTH-1:0] RS1_DATA,
  output logic [DATA_WIDTH-1:0] RS2_DATA,
  output logic                  WB_EN,
  output logic [4:0]            WB_RD,
  output logic [DATA_WIDTH-1:0] WB_DATA
);

  typedef struct packed {
    logic                  valid;
    logic [4:0]            rd;
    logic                  is_ld;
    logic [DATA_WIDTH-1:0] data;
  } slot_t;

  localparam slot_t Bubble = '0;

  slot_t                 mem1_q, mem1_d;
  slot_t                 mem2_q, mem2_d;
  slot_t                 mem3_q, mem3_d;
  logic                  wb_valid_q, wb_valid_d;
  logic [4:0]            wb_rd_q, wb_rd_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic [DATA_WIDTH-1:0] written_data_q, written_data_d;

  logic  adv;
  logic  is_alu, is_ld;
  slot_t capture;

  assign adv    = DATA_CACHE_READY & INS_CACHE_READY;
  assign is_alu = (EX2_TYPE == 2'b01);
  assign is_ld  = (EX2_TYPE == 2'b10);

  always_comb begin
    capture       = Bubble;
    capture.valid = EX2_VALID & (is_alu | is_ld) & (EX2_RD != 5'd0);
    capture.rd    = EX2_RD;
    capture.is_ld = is_ld;
    capture.data  = is_alu ? EX2_DATA : '0;
  end

  always_comb begin
    mem1_d         = mem1_q;
    mem2_d         = mem2_q;
    mem3_d         = mem3_q;
    wb_valid_d     = wb_valid_q;
    wb_rd_d        = wb_rd_q;
    wb_data_d      = wb_data_q;
    written_data_d = written_data_q;
    if (adv) begin
      mem1_d         = STALL_ENABLE_FB ? capture : Bubble;
      mem2_d         = mem1_q;
      mem3_d         = mem2_q;
      wb_valid_d     = mem3_q.valid;
      wb_rd_d        = mem3_q.rd;
      wb_data_d      = mem3_q.is_ld ? LOAD_DATA : mem3_q.data;
      written_data_d = wb_data_q;
    end
    // A flushed MEM1 entry must not advance, so MEM2 is also cleared on an advancing edge.
    if (FLUSH) begin
      mem1_d = Bubble;
      if (adv) begin
        mem2_d = Bubble;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      mem1_q         <= Bubble;
      mem2_q         <= Bubble;
      mem3_q         <= Bubble;
      wb_valid_q     <= 1'b0;
      wb_rd_q        <= 5'd0;
      wb_data_q      <= '0;
      written_data_q <= '0;
    end else begin
      mem1_q         <= mem1_d;
      mem2_q         <= mem2_d;
      mem3_q         <= mem3_d;
      wb_valid_q     <= wb_valid_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
      written_data_q <= written_data_d;
    end
  end

  assign WB_EN   = wb_valid_q;
  assign WB_RD   = wb_rd_q;
  assign WB_DATA = wb_data_q;

  // Slot valid bits are deliberately not checked; the tracker only issues legal selects.
  always_comb begin
    unique case (MUX1_SELECT)
      3'd1:    RS1_DATA = EX2_DATA;
      3'd2:    RS1_DATA = mem1_q.data;
      3'd3:    RS1_DATA = mem2_q.data;
      3'd4:    RS1_DATA = mem3_q.data;
      3'd5:    RS1_DATA = wb_data_q;
      3'd6:    RS1_DATA = written_data_q;
      default: RS1_DATA = RF1_DATA;
    endcase
  end

  always_comb begin
    unique case (MUX2_SELECT)
      3'd1:    RS2_DATA = EX2_DATA;
      3'd2:    RS2_DATA = mem1_q.data;
      3'd3:    RS2_DATA = mem2_q.data;
      3'd4:    RS2_DATA = mem3_q.data;
      3'd5:    RS2_DATA = wb_data_q;
      3'd6:    RS2_DATA = written_data_q;
      default: RS2_DATA = RF2_DATA;
    endcase
  end

endmodule
